// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with 16x oversampling and a 2-flop input synchronizer.
// Each bit is sampled at its centre; rx_done or frame_err pulses one cycle after the stop-bit sample.
module uart_rx #(
   parameter int CLKS_PER_TICK = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data_out,
   output logic       rx_done,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [11:0] TICK_MAX = 12'(CLKS_PER_TICK - 1);

   state_t      state_q, state_d;
   logic        sync1_q, rxd_s_q;
   logic [11:0] tcnt_q, tcnt_d;
   logic        tick;
   logic [3:0]  s_cnt_q, s_cnt_d;
   logic [2:0]  b_cnt_q, b_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        ferr_q, ferr_d;

   assign tick = (tcnt_q == TICK_MAX);

   // Counters advance only on the oversample tick; a new frame starts from s_cnt = 0
   // so the start bit is re-checked 8 ticks later, at its centre.
   always_comb begin
      tcnt_d  = tick ? 12'd0 : tcnt_q + 12'd1;
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      b_cnt_d = b_cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rxd_s_q) begin
                  s_cnt_d = 4'd0;
                  state_d = START;
               end
            end
            START: begin
               if (s_cnt_q == 4'd7) begin
                  if (!rxd_s_q) begin
                     state_d = DATA;
                     s_cnt_d = 4'd0;
                     b_cnt_d = 3'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (s_cnt_q == 4'd15) begin
                  shift_d = {rxd_s_q, shift_q[7:1]};
                  s_cnt_d = 4'd0;
                  if (b_cnt_q == 3'd7) begin
                     state_d = STOP;
                  end else begin
                     b_cnt_d = b_cnt_q + 3'd1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            STOP: begin
               if (s_cnt_q == 4'd15) begin
                  state_d = IDLE;
                  s_cnt_d = 4'd0;
                  if (rxd_s_q) begin
                     done_d = 1'b1;
                     data_d = shift_q;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rxd_s_q <= 1'b1;
         tcnt_q  <= 12'd0;
         state_q <= IDLE;
         s_cnt_q <= 4'd0;
         b_cnt_q <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rxd;
         rxd_s_q <= sync1_q;
         tcnt_q  <= tcnt_d;
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         b_cnt_q <= b_cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out  = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_TICK = 4 (one bit = 64 clk).
module tb_uart_rx;

   localparam int CPT = 4;
   localparam int BIT = 16 * CPT;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data_out;
   logic       rx_done;
   logic       frame_err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   logic [7:0] rx_log [0:15];

   uart_rx #(.CLKS_PER_TICK(CPT)) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .data_out(data_out),
      .rx_done(rx_done),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts output pulses and logs each received byte.
   always @(negedge clk) begin
      if (reset) begin
         if (rx_done === 1'b1) begin
            if (done_cnt < 16) rx_log[done_cnt] = data_out;
            done_cnt++;
         end
         if (frame_err === 1'b1) ferr_cnt++;
         if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic driveBit(input logic v, input int dur);
      rxd = v;
      repeat (dur) @(negedge clk);
   endtask

   // One 8N1 frame; jit moves bit edges +/-3 clk, a bad stop bit is held low for 48 clk.
   task automatic applyStimulus(input logic [7:0] data, input logic stop, input bit jit);
      int prev;
      int e;
      logic v;
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         e = BIT * (i + 1) + (jit ? ((i % 2 == 0) ? 3 : -3) : 0);
         if (i == 0) v = 1'b0;
         else if (i == 9) v = stop;
         else v = data[i-1];
         if (i == 9 && !stop) driveBit(v, 48);
         else driveBit(v, e - prev);
         prev = e;
      end
      rxd = 1'b1;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      checkOutput("reset_data_out", data_out, 8'h00);
      checkOutput("reset_rx_done", rx_done, 1'b0);
      checkOutput("reset_frame_err", frame_err, 1'b0);
      reset = 1'b1;
      repeat (2 * BIT) @(negedge clk);

      applyStimulus(8'h55, 1'b0, 1'b0);
      repeat (BIT) @(negedge clk);
      checkOutput("ferr_count_55", ferr_cnt, 1);
      checkOutput("ferr_no_done", done_cnt, 0);
      checkOutput("ferr_data_kept", data_out, 8'h00);

      applyStimulus(8'hA5, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk);
      checkOutput("a5_done_count", done_cnt, 1);
      checkOutput("a5_logged", rx_log[0], 8'hA5);
      checkOutput("a5_data_out", data_out, 8'hA5);
      checkOutput("a5_no_ferr", ferr_cnt, 1);

      applyStimulus(8'h3C, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk);
      checkOutput("b2b_done_count", done_cnt, 3);
      checkOutput("b2b_first", rx_log[1], 8'h3C);
      checkOutput("b2b_second", rx_log[2], 8'hFF);
      checkOutput("b2b_data_out", data_out, 8'hFF);

      driveBit(1'b0, 16);
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checkOutput("glitch_no_done", done_cnt, 3);
      checkOutput("glitch_no_ferr", ferr_cnt, 1);
      applyStimulus(8'h01, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk);
      checkOutput("post_glitch_done", done_cnt, 4);
      checkOutput("post_glitch_data", data_out, 8'h01);

      driveBit(1'b0, BIT);
      for (int i = 0; i < 4; i++) driveBit(1'b0, BIT);
      driveBit(1'b1, BIT / 2);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midreset_rx_done", rx_done, 1'b0);
      checkOutput("midreset_frame_err", frame_err, 1'b0);
      checkOutput("midreset_data_out", data_out, 8'h00);
      reset = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      checkOutput("abort_no_done", done_cnt, 4);
      checkOutput("abort_no_ferr", ferr_cnt, 1);
      applyStimulus(8'h0F, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk);
      checkOutput("after_abort_done", done_cnt, 5);
      checkOutput("after_abort_data", data_out, 8'h0F);

      applyStimulus(8'h00, 1'b1, 1'b1);
      repeat (BIT) @(negedge clk);
      applyStimulus(8'hFF, 1'b1, 1'b1);
      repeat (BIT) @(negedge clk);
      checkOutput("jitter_done_count", done_cnt, 7);
      checkOutput("jitter_byte_00", rx_log[5], 8'h00);
      checkOutput("jitter_byte_ff", rx_log[6], 8'hFF);
      checkOutput("jitter_no_ferr", ferr_cnt, 1);
      checkOutput("never_both_pulses", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
